// File: rtl/sb_pkg.sv
// sb_pkg: shared system-bus state encoding and bus width constants
package sb_pkg;
  localparam int SB_DATA_W  = 32;
  localparam int SB_BE_W    = 4;
  localparam int SB_BURST_W = 8;
  typedef enum logic [2:0] {
    SB_IDLE,
    SB_WAIT,
    SB_RD_DATA,
    SB_RD_END,
    SB_WR_DATA,
    SB_ERROR
  } sb_state_e;
endpackage

// File: rtl/sb_mem_slave_ram.sv
// sb_mem_slave_ram: single-port synchronous RAM with per-byte write enables and registered read
module sb_mem_slave_ram
  import sb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [SB_BE_W-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SB_DATA_W-1:0]  wdata,
  output logic [SB_DATA_W-1:0]  rdata
);
  logic [SB_DATA_W-1:0] mem [2**ADDR_WIDTH];
  // byte-lane writes; the read returns the word as it was before this edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < SB_BE_W; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sb_mem_slave.sv
// sb_mem_slave: bus memory target; SB_MEM_SLAVE_WAIT_EN inserts WAIT_CYCLES busy cycles per transaction
module sb_mem_slave
  import sb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                  sb_clock_i,
  input  logic                  sb_reset_n_i,
  input  logic                  sb_begin_transaction_i,
  input  logic [SB_DATA_W-1:0]  sb_address_data_i,
  input  logic [SB_BE_W-1:0]    sb_byte_enables_i,
  input  logic [SB_BURST_W-1:0] sb_burst_size_i,
  input  logic                  sb_read_n_write_i,
  input  logic                  sb_data_valid_i,
  input  logic                  sb_end_transaction_i,
  output logic [SB_DATA_W-1:0]  sb_address_data_o,
  output logic                  sb_data_valid_o,
  output logic                  sb_end_transaction_o,
  output logic                  sb_busy_o,
  output logic                  sb_error_o
);
`ifdef SB_MEM_SLAVE_WAIT_EN
  localparam int WAIT_N = WAIT_CYCLES;
`else
  localparam int WAIT_N = 0 * WAIT_CYCLES;
`endif
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  sb_state_e             state, state_d;
  logic [ADDR_WIDTH-1:0] ptr, ptr_d, ram_addr;
  logic [SB_BURST_W:0]   left, left_d;
  logic [7:0]            wcnt, wcnt_d;
  logic                  rd, rd_d, sel, mis;
  logic [SB_BE_W-1:0]    we;
  logic [SB_DATA_W-1:0]  rdata;
  assign sel = sb_begin_transaction_i &&
               (sb_address_data_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign mis = |sb_address_data_i[1:0];
  // reads are addressed by the next pointer so the registered RAM output lines up with the beat
  assign ram_addr = (state == SB_WR_DATA) ? ptr : ptr_d;
  sb_mem_slave_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk  (sb_clock_i),
    .we   (we),
    .addr (ram_addr),
    .wdata(sb_address_data_i),
    .rdata(rdata)
  );
  // state, pointer and remaining-beat registers
  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      state <= SB_IDLE;
      ptr   <= '0;
      left  <= '0;
      wcnt  <= '0;
      rd    <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      left  <= left_d;
      wcnt  <= wcnt_d;
      rd    <= rd_d;
    end
  end
  // next state, pointer advance and write strobes; left holds beats still owed (burst_size+1 at start)
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    left_d  = left;
    wcnt_d  = wcnt;
    rd_d    = rd;
    we      = '0;
    case (state)
      SB_IDLE: if (sel) begin
        ptr_d   = sb_address_data_i[ADDR_WIDTH+1:2];
        left_d  = {1'b0, sb_burst_size_i} + 9'd1;
        rd_d    = sb_read_n_write_i;
        wcnt_d  = 8'(WAIT_N - 1);
        state_d = mis ? SB_ERROR : (WAIT_N > 0) ? SB_WAIT :
                  sb_read_n_write_i ? SB_RD_DATA : SB_WR_DATA;
      end
      SB_WAIT: begin
        wcnt_d  = wcnt - 8'd1;
        state_d = sb_end_transaction_i ? SB_IDLE : (wcnt != 8'd0) ? SB_WAIT :
                  rd ? SB_RD_DATA : SB_WR_DATA;
      end
      SB_RD_DATA: begin
        ptr_d   = ptr + ONE;
        left_d  = left - 9'd1;
        state_d = sb_end_transaction_i ? SB_IDLE : (left == 9'd1) ? SB_RD_END : SB_RD_DATA;
      end
      SB_WR_DATA: begin
        if (sb_data_valid_i && left != 9'd0) begin
          we     = sb_byte_enables_i;
          ptr_d  = ptr + ONE;
          left_d = left - 9'd1;
        end
        if (sb_end_transaction_i) state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end
  // bus outputs decoded from registered state, zero whenever this slave is not driving
  always_comb begin
    sb_data_valid_o      = (state == SB_RD_DATA);
    sb_address_data_o    = sb_data_valid_o ? rdata : '0;
    sb_end_transaction_o = (state == SB_RD_END) || (state == SB_ERROR);
    sb_error_o           = (state == SB_ERROR);
    sb_busy_o            = (state == SB_WAIT);
  end
endmodule

// File: doc/sb_mem_slave.md
# sb_mem_slave

Word-addressed memory responder for the shared system bus. It is the target end of the burst protocol driven by the JTAG debug bridge and other bus masters. It decodes a begin-transaction address phase, serves single or burst reads by returning data beats followed by end-transaction, and absorbs write beats with byte enables. All bus outputs are zero when not selected so they can be OR-combined onto the bus. It replaces the emulated SDRAM stub in bus-level benches and serves as on-chip scratch RAM.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base address of the window.
- ADDR_WIDTH, 10: word-address bits; DEPTH = 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2: busy cycles inserted per transaction (used only with SB_MEM_SLAVE_WAIT_EN).
- sb_clock_i  in  1  bus clock; all logic on rising edge.
- sb_reset_n_i  in  1  asynchronous, active-low reset.
- sb_begin_transaction_i  in  1  address phase strobe.
- sb_address_data_i  in  32  address (at begin), write data (at data_valid).
- sb_byte_enables_i  in  4  byte lanes for write beats.
- sb_burst_size_i  in  8  beats minus one, sampled at begin.
- sb_read_n_write_i  in  1  1 = read, sampled at begin.
- sb_data_valid_i  in  1  master write-beat strobe.
- sb_end_transaction_i  in  1  master end (write completion or abort).
- sb_address_data_o  out  32  read data; 0 when sb_data_valid_o low.
- sb_data_valid_o  out  1  read-beat strobe.
- sb_end_transaction_o  out  1  slave end of read burst or error.
- sb_busy_o  out  1  write data not accepted this cycle.
- sb_error_o  out  1  one-cycle error pulse.

## Operation
- Selected when begin is high and address[31:ADDR_WIDTH+2] equals BASE_ADDR[31:ADDR_WIDTH+2]. Otherwise the transaction is ignored and all outputs stay 0.
- Latched at begin: word pointer = address[ADDR_WIDTH+1:2]; beat counter = burst_size; direction.
- Misaligned address (address[1:0] != 0) while selected triggers ERROR: sb_error_o=1 and sb_end_transaction_o=1 for one cycle, then IDLE. For a write, data beats arriving after the error are dropped.
- States:
  - IDLE
  - WAIT (only with the macro)
  - RD_DATA
  - RD_END
  - WR_DATA
  - ERROR
- IDLE: on selected begin, go to RD_DATA or WR_DATA (or WAIT with the macro).
- RD_DATA: one beat per cycle, no gaps. sb_data_valid_o=1 with mem[ptr]; ptr increments and the counter decrements. After the last beat (counter was 0), go to RD_END.
- RD_END: sb_end_transaction_o=1 for one cycle, then IDLE.
- WR_DATA: each cycle with data_valid_i=1 and busy_o=0 writes the lanes selected by byte_enables into mem[ptr], then ptr increments.
  - Beats beyond burst_size+1 are dropped.
  - Go to IDLE on sampling sb_end_transaction_i.
  - The slave never drives end on writes.
- Pointer wraps modulo DEPTH. A burst crossing the top of the window continues at word 0.
- Master end_transaction_i during RD_DATA or WAIT aborts: outputs go to 0 in the next cycle and the state returns to IDLE with no RD_END.
- begin_transaction_i outside IDLE is ignored.
- Byte enables are ignored on reads. A write beat with byte_enables=0 still consumes a beat.

## Timing
- Reset: all outputs 0, state IDLE, pointer and counter 0. RAM contents are not reset.
- Reset asserted mid-transaction: outputs drop to 0 asynchronously. No end or error is emitted.
- Read latency: begin sampled at edge N; first data_valid_o is high in cycle N+1 (synchronous RAM read addressed combinationally from the latched pointer). Beat k is in cycle N+1+k. End is in cycle N+2+burst_size.
- Write: the earliest beat is accepted in the cycle after begin. Same-cycle write-then-read of the same word is not possible; bus ordering guarantees this.
- Error: error and end pulses occur in cycle N+1.
- All outputs are registered or derived from registered state plus RAM output. There are no combinational input-to-output paths.

## Configuration
- SB_MEM_SLAVE_WAIT_EN defined:
  - Selected transactions pass through WAIT for WAIT_CYCLES cycles after begin.
  - sb_busy_o=1 throughout WAIT.
  - Read latency grows by WAIT_CYCLES.
  - On writes, a data_valid_i arriving during WAIT is not accepted; the master holds it until busy falls.
  - WAIT_CYCLES=0 behaves as undefined.
- Undefined: there is no WAIT state, sb_busy_o is tied to 0, and WAIT_CYCLES is unused.

## Structure
- Shared sb_pkg holds:
  - the state enum (SB_IDLE … SB_ERROR);
  - bus width constants (SB_DATA_W=32, SB_BE_W=4, SB_BURST_W=8).
- Sub-module sb_mem_slave_ram: single-port synchronous RAM, DEPTH×32, per-byte write enables, registered read. It is the only storage element.

## Test plan
- Write 1 beat 0xDEADBEEF, BE=4'hF to BASE+0x10, then read 1 beat -> data_valid one cycle after begin with 0xDEADBEEF, end the following cycle.
- Write burst_size=3 of 0x11..0x44, then read burst_size=3 -> four consecutive beats 0x11,0x22,0x33,0x44, then a single end pulse.
- Write BE=4'b0010 data 0xFFFFFFFF over 0x00000000 -> readback 0x0000FF00.
- Read burst_size=1 starting at the last word (DEPTH-1) -> beats mem[DEPTH-1] then mem[0].
- Begin at address BASE+0x2 -> error and end high for exactly one cycle, no data_valid. Begin outside the window -> all outputs 0 throughout.
- With SB_MEM_SLAVE_WAIT_EN and WAIT_CYCLES=2: busy high for 2 cycles and first read beat at begin+3. Separately, pull reset low mid-read -> outputs 0 immediately and state IDLE after release.
